// File: rtl/text_line_drawer.sv
// Sequences one line of text into symbol_drawer: fetches each character from the
// text RAM, latches the cell registers, fires a one-cycle start and waits for completion.
module text_line_drawer #(
  parameter int MAX_LEN      = 32,
  parameter int X0           = 0,
  parameter int Y0           = 200,
  parameter int SYMBOL_PITCH = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       ready,
  input  logic [5:0] len,
  input  logic [5:0] cursor_pos,
  output logic [4:0] char_read_addr,
  input  logic [6:0] char_read_data,
  output logic       symbol_drawer_start,
  input  logic       symbol_drawer_ready,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic [6:0] symbol,
  output logic       cursor_left,
  output logic       cursor_right
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_FIRE, S_GUARD, S_WAIT
  } state_t;

  state_t     state_q;
  logic [5:0] i_q, len_q, cur_q;
  logic [5:0] i_d, len_d, cur_d;
  logic [9:0] x_acc_q;
  logic [9:0] x_q;
  logic [8:0] y_q;
  logic [6:0] symbol_q;
  logic       cursor_left_q, cursor_right_q;
  logic       sd_start_q;
  logic [4:0] addr_q;

  // Clamp the requested length and cursor at accept time.
  always_comb begin
    len_d = (len > 6'(MAX_LEN)) ? 6'(MAX_LEN) : len;
    cur_d = (cursor_pos > len_d) ? len_d : cursor_pos;
    i_d   = i_q + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      i_q            <= '0;
      len_q          <= '0;
      cur_q          <= '0;
      x_acc_q        <= 10'(X0);
      x_q            <= 10'(X0);
      y_q            <= 9'(Y0);
      symbol_q       <= '0;
      cursor_left_q  <= 1'b0;
      cursor_right_q <= 1'b0;
      sd_start_q     <= 1'b0;
      addr_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && symbol_drawer_ready) begin
            len_q   <= len_d;
            cur_q   <= cur_d;
            i_q     <= '0;
            addr_q  <= '0;
            x_acc_q <= 10'(X0);
            state_q <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_LATCH;
        S_LATCH: begin
          // An empty line still draws one blank cell carrying the cursor.
          symbol_q       <= (len_q == 6'd0) ? 7'd0 : char_read_data;
          x_q            <= x_acc_q;
          y_q            <= 9'(Y0);
          cursor_left_q  <= (cur_q == i_q);
          cursor_right_q <= (cur_q == i_d);
          sd_start_q     <= 1'b1;
          state_q        <= S_FIRE;
        end
        S_FIRE: begin
          sd_start_q <= 1'b0;
          state_q    <= S_GUARD;
        end
        // symbol_drawer drops ready one cycle after start; skip that stale cycle.
        S_GUARD: state_q <= S_WAIT;
        S_WAIT: begin
          if (symbol_drawer_ready) begin
            if (i_d >= len_q) begin
              state_q <= S_IDLE;
            end else begin
              i_q     <= i_d;
              addr_q  <= i_d[4:0];
              x_acc_q <= x_acc_q + 10'(SYMBOL_PITCH);
              state_q <= S_FETCH;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready               = (state_q == S_IDLE) && symbol_drawer_ready;
  assign char_read_addr      = addr_q;
  assign symbol_drawer_start = sd_start_q;
  assign x                   = x_q;
  assign y                   = y_q;
  assign symbol              = symbol_q;
  assign cursor_left         = cursor_left_q;
  assign cursor_right        = cursor_right_q;

endmodule

// File: tb/tb_text_line_drawer.sv
// Scoreboard bench for text_line_drawer with a text RAM and a busy symbol_drawer model.
module tb_text_line_drawer;
  localparam int BUSY = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] len = '0, cursor_pos = '0;
  logic       ready;
  logic [4:0] char_read_addr;
  logic [6:0] char_read_data;
  logic       symbol_drawer_start;
  logic       sd_ready = 1'b1;
  logic [9:0] x;
  logic [8:0] y;
  logic [6:0] symbol;
  logic       cursor_left, cursor_right;

  text_line_drawer dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .len(len),
    .cursor_pos(cursor_pos), .char_read_addr(char_read_addr),
    .char_read_data(char_read_data), .symbol_drawer_start(symbol_drawer_start),
    .symbol_drawer_ready(sd_ready), .x(x), .y(y), .symbol(symbol),
    .cursor_left(cursor_left), .cursor_right(cursor_right)
  );

  logic [6:0] mem [32];
  always @(posedge clk) char_read_data <= mem[char_read_addr];

  // symbol_drawer model: drops ready the cycle after start, busy for BUSY cycles.
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (symbol_drawer_start) begin
      sd_ready <= 1'b0;
      busy_cnt <= BUSY;
    end else if (!sd_ready) begin
      if (busy_cnt <= 1) sd_ready <= 1'b1;
      else busy_cnt <= busy_cnt - 1;
    end
  end

  typedef struct {
    int x;
    int sym;
    int cl;
    int cr;
  } cell_t;

  cell_t exp_q[$];
  int n_err = 0, n_chk = 0, pulses = 0, last_x = -1;

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every start pulse, checks hold until ready returns.
  logic  prev_start = 1'b0, prev_sd = 1'b1, have_cell = 1'b0;
  cell_t held, e;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      have_cell = 1'b0;
    end else begin
      if (have_cell && sd_ready && !prev_sd) begin
        check("stable_x", int'(x), held.x);
        check("stable_sym", int'(symbol), held.sym);
        check("stable_cl", int'(cursor_left), held.cl);
        check("stable_cr", int'(cursor_right), held.cr);
        have_cell = 1'b0;
      end
      if (symbol_drawer_start) begin
        pulses++;
        last_x = int'(x);
        check("pulse_width", int'(prev_start), 0);
        check("pulse_while_busy", int'(sd_ready), 1);
        check("cell_y", int'(y), 200);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("cell_x", int'(x), e.x);
          check("cell_sym", int'(symbol), e.sym);
          check("cell_cl", int'(cursor_left), e.cl);
          check("cell_cr", int'(cursor_right), e.cr);
        end
        held.x = int'(x);
        held.sym = int'(symbol);
        held.cl = int'(cursor_left);
        held.cr = int'(cursor_right);
        have_cell = 1'b1;
      end
    end
    prev_start = symbol_drawer_start;
    prev_sd = sd_ready;
  end

  task automatic push(int xx, int s, int cl, int cr);
    cell_t c;
    c.x = xx; c.sym = s; c.cl = cl; c.cr = cr;
    exp_q.push_back(c);
  endtask

  task automatic fire(int l, int c);
    @(posedge clk);
    #1 len = 6'(l); cursor_pos = 6'(c); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(string name);
    int ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && ready) begin
        ok = 1;
        break;
      end
    end
    check({name, "_done"}, ok, 1);
  endtask

  task automatic push_hello3(int cr_last);
    push(0, 8'h68, 0, 0);
    push(15, 8'h65, 0, 0);
    push(30, 8'h6c, 0, cr_last);
  endtask

  task automatic push_hello5();
    push(0, 8'h68, 0, 1);
    push(15, 8'h65, 1, 0);
    push(30, 8'h6c, 0, 0);
    push(45, 8'h6c, 0, 0);
    push(60, 8'h6f, 0, 0);
  endtask

  int p0;
  int ok;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 7'(65 + i);
    mem[0] = 7'h68; mem[1] = 7'h65; mem[2] = 7'h6c; mem[3] = 7'h6c; mem[4] = 7'h6f;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_start", int'(symbol_drawer_start), 0);
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 200);
    check("rst_symbol", int'(symbol), 0);
    check("rst_cl", int'(cursor_left), 0);
    check("rst_cr", int'(cursor_right), 0);
    check("rst_addr", int'(char_read_addr), 0);

    p0 = pulses; push_hello5(); fire(5, 1); wait_done("hello");
    check("hello_pulses", pulses - p0, 5);
    @(negedge clk);
    check("hello_ready_after", int'(ready), 1);

    p0 = pulses; push(0, 0, 1, 0); fire(0, 0); wait_done("empty");
    check("empty_pulses", pulses - p0, 1);

    // A start while busy must be dropped.
    p0 = pulses; push_hello3(1); fire(3, 3);
    repeat (30) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("len3_cur3");
    check("len3_cur3_pulses", pulses - p0, 3);

    p0 = pulses; push_hello3(1); fire(3, 7); wait_done("len3_cur7");
    check("len3_cur7_pulses", pulses - p0, 3);

    p0 = pulses;
    for (int i = 0; i < 32; i++) push(15 * i, int'(mem[i]), 0, (i == 31) ? 1 : 0);
    fire(40, 40); wait_done("len40");
    check("len40_pulses", pulses - p0, 32);
    check("len40_last_x", last_x, 465);

    // Reset while symbol_drawer is busy with the second cell.
    p0 = pulses; push_hello5(); fire(5, 1);
    ok = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (pulses - p0 >= 2) begin ok = 1; break; end
    end
    check("rst_mid_reach", ok, 1);
    repeat (3) @(negedge clk);
    check("rst_mid_sd_busy", int'(sd_ready), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready_low", int'(ready), 0);
    check("rst_mid_start_low", int'(symbol_drawer_start), 0);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      if (sd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check("rst_mid_sd_back", ok, 1);
    check("rst_mid_ready_back", int'(ready), 1);
    check("rst_mid_pulses", pulses - p0, 2);

    p0 = pulses; push_hello5(); fire(5, 1); wait_done("redraw");
    check("redraw_pulses", pulses - p0, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
